// File: rtl/interrupt_controller_if.sv
// Interrupt-acknowledge handshake between the interrupt controller (master)
// and the pipeline fetch/IACK chain (slave).
interface interrupt_controller_if #(
    parameter int ID_W = 3
);
    logic            int_req;
    logic [31:0]     vector_pc;
    logic [ID_W-1:0] active_id;
    logic            busy;
    logic            IACK_in;
    logic            eoi;

    modport master (
        output int_req,
        output vector_pc,
        output active_id,
        output busy,
        input  IACK_in,
        input  eoi
    );

    modport slave (
        input  int_req,
        input  vector_pc,
        input  active_id,
        input  busy,
        output IACK_in,
        output eoi
    );
endinterface

// File: rtl/interrupt_controller.sv
// Requester side of the interrupt-acknowledge protocol.
// Latches rising edges of the device lines, masks and prioritises them
// (index 0 highest), requests the fetch stage with a vector PC, waits for
// IACK and tracks the in-service interrupt until end-of-interrupt.
// Optional build macro NESTED_IRQ_EN: a per-line in-service register lets a
// higher-priority interrupt pre-empt the one being serviced.
module interrupt_controller #(
    parameter int          ID_W         = 3,
    parameter logic [31:0] VECTOR_BASE  = 32'h0000_0080,
    parameter int          VECTOR_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [(1 << ID_W)-1:0]   irq_in,
    input  logic                     mask_we,
    input  logic [(1 << ID_W)-1:0]   mask_wdata,
    output logic [(1 << ID_W)-1:0]   mask_out,
    output logic [(1 << ID_W)-1:0]   pending_out,
    interrupt_controller_if.master   bus
);
    localparam int NUM_IRQ = 1 << ID_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] eligible;
    logic               cand_vld;
    logic [ID_W-1:0]    cand_id;
    logic               int_req;
    logic [31:0]        vector_pc;
    logic [ID_W-1:0]    req_id;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_IRQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
        logic [31:0] ext;
        ext = 32'(id);
        return VECTOR_BASE + (ext << VECTOR_SHIFT);
    endfunction

    assign edge_det    = irq_in & ~irq_prev;
    assign eligible    = pending & ~mask;
    assign cand_vld    = |eligible;
    assign cand_id     = lowest_set(eligible);
    assign mask_out    = mask;
    assign pending_out = pending;

    assign bus.int_req   = int_req;
    assign bus.vector_pc = vector_pc;

    // The acknowledged request's pending bit is cleared on the IACK edge.
    always_comb begin
        clr = '0;
        if (state == REQ && bus.IACK_in) clr = onehot(req_id);
    end

    // Edge detector, pending latch (a same-cycle edge beats the clear) and mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '1;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr) | edge_det;
            if (mask_we) mask <= mask_wdata;
        end
    end

`ifdef NESTED_IRQ_EN
    logic [NUM_IRQ-1:0] in_service;
    logic [ID_W-1:0]    isr_id;
    logic               preempt_ok;

    assign isr_id        = lowest_set(in_service);
    assign preempt_ok    = (in_service == '0) || (cand_id < isr_id);
    assign bus.busy      = int_req | (|in_service);
    assign bus.active_id = int_req ? req_id : isr_id;

    // Request FSM with nesting: IDLE also covers "servicing, nothing new to ask".
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            vector_pc  <= '0;
            req_id     <= '0;
            in_service <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.eoi && (in_service != '0))
                        in_service <= in_service & ~onehot(isr_id);
                    if (cand_vld && preempt_ok) begin
                        req_id    <= cand_id;
                        vector_pc <= vec_of(cand_id);
                        int_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.IACK_in) begin
                        in_service <= in_service | onehot(req_id);
                        int_req    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic busy;

    assign bus.busy      = busy;
    assign bus.active_id = req_id;

    // Request FSM: one interrupt at a time, committed request held until IACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            int_req   <= 1'b0;
            vector_pc <= '0;
            req_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_vld) begin
                        req_id    <= cand_id;
                        vector_pc <= vec_of(cand_id);
                        int_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.IACK_in) begin
                        int_req <= 1'b0;
                        state   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule
